// File: rtl/uart_alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer_pkg
// Shared definitions for the UART/ALU sequencer and the ALU it drives:
//   - default widths for data bytes, opcodes and the inter-byte timeout counter
//   - one-hot sequencer state encoding
//   - opcode constants understood by the ALU
// -----------------------------------------------------------------------------
package uart_alu_sequencer_pkg;

  localparam int N_BITS_DATA_DEF    = 8;
  localparam int N_BITS_OP_DEF      = 6;
  localparam int N_BITS_TIMEOUT_DEF = 20;

  typedef enum logic [5:0] {
    WAIT_A  = 6'b000001,
    WAIT_B  = 6'b000010,
    WAIT_OP = 6'b000100,
    EXEC    = 6'b001000,
    SEND    = 6'b010000,
    WAIT_TX = 6'b100000
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_sequencer_timeout_counter.sv
// -----------------------------------------------------------------------------
// seq_timeout_counter
// Free-running up-counter that measures idle time between received bytes.
// Ports:
//   clock    in  system clock
//   reset    in  synchronous, active-high reset
//   clear    in  forces the count to zero (higher priority than enable)
//   enable   in  advance the count by one this cycle
//   terminal out count is all-ones
// -----------------------------------------------------------------------------
module seq_timeout_counter #(
  parameter int N_BITS = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [N_BITS-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = &count;

endmodule

// File: rtl/uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// uart_alu_sequencer
// Collects operand A, operand B and opcode bytes from a UART receiver, presents
// them as registered ALU inputs, captures the ALU result and hands it to the
// UART transmitter with a one-cycle start pulse, then waits for the transmitter
// to finish before accepting the next frame.
//
// Optional build macro SEQ_TIMEOUT_EN: abandons a partial frame (back to
// WAIT_A) when no byte arrives for 2**N_BITS_TIMEOUT-1 cycles in WAIT_B or
// WAIT_OP. Without it a partial frame waits indefinitely.
//
// Ports:
//   clock, reset     system clock; synchronous active-high reset
//   rx_done_tick     pulse: rx_data holds a new byte
//   rx_data          byte from the receiver
//   tx_done_tick     pulse: transmitter finished (honoured in WAIT_TX only)
//   tx_start         one-cycle transmit request
//   tx_data          byte to transmit, held until the next EXEC
//   alu_a/alu_b      registered operands
//   alu_op           registered opcode (low N_BITS_OP bits of the third byte)
//   alu_result       combinational ALU result
//   busy             high in EXEC, SEND, WAIT_TX
//   overrun          sticky: a byte arrived while busy and was dropped
// -----------------------------------------------------------------------------
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int N_BITS_DATA    = N_BITS_DATA_DEF,
  parameter int N_BITS_OP      = N_BITS_OP_DEF,
  parameter int N_BITS_TIMEOUT = N_BITS_TIMEOUT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_done_tick,
  input  logic [N_BITS_DATA-1:0] rx_data,
  input  logic                   tx_done_tick,
  output logic                   tx_start,
  output logic [N_BITS_DATA-1:0] tx_data,
  output logic [N_BITS_DATA-1:0] alu_a,
  output logic [N_BITS_DATA-1:0] alu_b,
  output logic [N_BITS_OP-1:0]   alu_op,
  input  logic [N_BITS_DATA-1:0] alu_result,
  output logic                   busy,
  output logic                   overrun
);

  state_t state;
  logic   timeout;

`ifdef SEQ_TIMEOUT_EN
  logic in_partial;
  logic accept;
  logic terminal;

  assign in_partial = (state == WAIT_B) || (state == WAIT_OP);
  assign accept     = rx_done_tick && ((state == WAIT_A) || in_partial);

  // Counter is held at zero outside WAIT_B/WAIT_OP, which covers the
  // "clear on entry to WAIT_A" case; an accepted byte always clears it.
  seq_timeout_counter #(
    .N_BITS (N_BITS_TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept || !in_partial || terminal),
    .enable   (in_partial),
    .terminal (terminal)
  );

  assign timeout = terminal && in_partial;
`else
  logic [N_BITS_TIMEOUT-1:0] unused_timeout_count;
  assign unused_timeout_count = '0;
  assign timeout              = 1'b0;
`endif

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WAIT_A;
      tx_start <= 1'b0;
      tx_data  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;

      if (rx_done_tick && (state inside {EXEC, SEND, WAIT_TX})) begin
        overrun <= 1'b1;
      end

      // NOTE: the default arm recovers from any non-one-hot encoding and
      // keeps the decode fully specified.
      case (state)
        WAIT_A: begin
          if (rx_done_tick) begin
            alu_a <= rx_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          // A byte arriving on the terminal count wins over the timeout.
          if (rx_done_tick) begin
            alu_b <= rx_data;
            state <= WAIT_OP;
          end else if (timeout) begin
            state <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (rx_done_tick) begin
            alu_op <= rx_data[N_BITS_OP-1:0];
            state  <= EXEC;
            busy   <= 1'b1;
          end else if (timeout) begin
            state <= WAIT_A;
          end
        end
        EXEC: begin
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) begin
            state <= WAIT_A;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_A;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_sequencer
// Table-driven frames through the sequencer with a small reference ALU, plus
// hand-written sequences for overrun, reset mid-frame / mid-transmit, ignored
// tx_done_tick and the inter-byte timeout (SEQ_TIMEOUT_EN, 4-bit counter).
// -----------------------------------------------------------------------------
module tb_uart_alu_sequencer;
  import uart_alu_sequencer_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_byte;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       busy;
  logic       overrun;

  int n_checks  = 0;
  int n_pass    = 0;
  int tx_pulses = 0;

  always #5 clock = ~clock;

  uart_alu_sequencer #(
    .N_BITS_DATA    (8),
    .N_BITS_OP      (6),
    .N_BITS_TIMEOUT (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Reference ALU; undefined opcodes yield a recognisable marker.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SRA:  alu_result = $signed(alu_a) >>> alu_b;
      OP_SRL:  alu_result = alu_a >> alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      default: alu_result = 8'hEE;
    endcase
  end

  always @(negedge clock) if (tx_start) tx_pulses++;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int p0;
    send_byte(v.a);
    send_byte(v.b);
    p0 = tx_pulses;
    send_byte(v.op_byte);
    // EXEC cycle
    check({tag, " alu_a"}, alu_a, v.a);
    check({tag, " alu_b"}, alu_b, v.b);
    check({tag, " alu_op"}, alu_op, v.exp_op);
    check({tag, " busy exec"}, busy, 1);
    check({tag, " tx_start exec"}, tx_start, 0);
    step();  // SEND cycle
    check({tag, " tx_start send"}, tx_start, 1);
    check({tag, " tx_data"}, tx_data, v.exp_tx);
    step();
    check({tag, " tx_start after"}, tx_start, 0);
    step(3);
    check({tag, " busy wait_tx"}, busy, 1);
    check({tag, " pulse count"}, tx_pulses - p0, 1);
    pulse_tx_done();
    check({tag, " busy done"}, busy, 0);
    check({tag, " tx_data hold"}, tx_data, v.exp_tx);
  endtask

  vec_t vecs[10];
  vec_t v;
  int   p0;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};  // ADD
    vecs[1] = '{8'hF0, 8'h0F, 8'hE5, 6'h25, 8'hFF};  // OR, upper opcode bits dropped
    vecs[2] = '{8'h10, 8'h20, 8'h22, 6'h22, 8'hF0};  // SUB wraps
    vecs[3] = '{8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08};  // AND
    vecs[4] = '{8'h0C, 8'h0A, 8'h26, 6'h26, 8'h06};  // XOR
    vecs[5] = '{8'h80, 8'h01, 8'h03, 6'h03, 8'hC0};  // SRA
    vecs[6] = '{8'h80, 8'h01, 8'h02, 6'h02, 8'h40};  // SRL
    vecs[7] = '{8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00};  // NOR
    vecs[8] = '{8'hAA, 8'h55, 8'hFF, 6'h3F, 8'hEE};  // undefined opcode
    vecs[9] = '{8'hFF, 8'h01, 8'h60, 6'h20, 8'h00};  // ADD wraps

    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    step(2);
    check("reset tx_start", tx_start, 0);
    check("reset tx_data", tx_data, 0);
    check("reset alu_a", alu_a, 0);
    check("reset alu_b", alu_b, 0);
    check("reset alu_op", alu_op, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b0;
    step();

    // tx_done_tick in WAIT_A is ignored
    p0 = tx_pulses;
    pulse_tx_done();
    step(2);
    check("idle txdone busy", busy, 0);
    check("idle txdone pulses", tx_pulses - p0, 0);

    for (int i = 0; i < 10; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
    check("no overrun after table", overrun, 0);

    // Overrun: byte in WAIT_TX, then byte coinciding with tx_done_tick
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    step(2);  // WAIT_TX
    send_byte(8'hAA);
    check("overrun set", overrun, 1);
    check("overrun busy", busy, 1);
    rx_data      = 8'hBB;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    check("coincident busy", busy, 0);
    check("coincident alu_a", alu_a, 8'h01);
    v = '{8'h03, 8'h04, 8'h20, 6'h20, 8'h07};
    run_frame(v, "post_overrun");
    check("overrun sticky", overrun, 1);

    // tx_done_tick in EXEC is ignored
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'h20);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("exec txdone tx_start", tx_start, 1);
    check("exec txdone tx_data", tx_data, 8'h04);
    step(2);
    check("exec txdone busy", busy, 1);
    pulse_tx_done();
    check("exec txdone release", busy, 0);

    // Reset one cycle after operand B
    send_byte(8'h11);
    send_byte(8'h22);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midframe rst alu_a", alu_a, 0);
    check("midframe rst alu_b", alu_b, 0);
    check("midframe rst tx_data", tx_data, 0);
    check("midframe rst overrun", overrun, 0);
    check("midframe rst busy", busy, 0);
    v = '{8'h07, 8'h02, 8'h22, 6'h22, 8'h05};
    run_frame(v, "post_reset");

    // Reset during EXEC: no transmit request afterwards
    send_byte(8'h01);
    send_byte(8'h01);
    p0 = tx_pulses;
    send_byte(8'h20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(4);
    check("exec rst pulses", tx_pulses - p0, 0);
    check("exec rst busy", busy, 0);
    check("exec rst tx_data", tx_data, 0);

    // Inter-byte timeout
    p0 = tx_pulses;
    send_byte(8'h11);
    step(20);
    check("timeout pulses", tx_pulses - p0, 0);
    check("timeout alu_a kept", alu_a, 8'h11);
`ifdef SEQ_TIMEOUT_EN
    v = '{8'h33, 8'h44, 8'h20, 6'h20, 8'h77};
    run_frame(v, "after_timeout");
`else
    send_byte(8'h22);
    send_byte(8'h20);
    check("no timeout alu_a", alu_a, 8'h11);
    check("no timeout alu_b", alu_b, 8'h22);
    step();
    check("no timeout tx_start", tx_start, 1);
    check("no timeout tx_data", tx_data, 8'h33);
    step(2);
    pulse_tx_done();
    check("no timeout done", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
